// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array and its operand feeder.
package systolic_pkg;

    localparam int unsigned DefBw = 8;
    localparam int unsigned DefN  = 5;

    typedef enum logic [1:0] {
        StLoad,
        StStream,
        StDrain,
        StDone
    } feederState_e;

    // Counter width helper that never collapses to a zero-width vector.
    function automatic int unsigned clogMin1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/systolic_skew_lane.sv
// One skewed edge lane: presents element (tIdx - LANE) of an N-element vector, or 0.
module systolic_skew_lane
    import systolic_pkg::*;
#(
    parameter int unsigned BW   = DefBw,
    parameter int unsigned N    = DefN,
    parameter int unsigned LANE = 0,
    parameter int unsigned TW   = 4
) (
    input  logic [TW-1:0]   tIdx,
    input  logic [N*BW-1:0] vec,
    output logic [BW-1:0]   elem_c
);

    // Element select with implicit zero padding outside the lane's window.
    always_comb begin
        elem_c = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (32'(tIdx) == 32'(k) + LANE) begin
                elem_c = vec[k*BW +: BW];
            end
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Loads operand matrices A (row-wise) and B (column-wise), streams them with
// diagonal skew into the systolic array edges, then drains and flags completion.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int unsigned BW    = DefBw,
    parameter int unsigned N     = DefN,
    parameter int unsigned DRAIN = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iValid,
    output logic            iReady,
    input  logic [N*BW-1:0] iData,
    output logic [BW-1:0]   oRow [0:N-1],
    output logic [BW-1:0]   oCol [0:N-1],
    output logic            oBusy,
    output logic            oDone
);

    localparam int unsigned BCW      = clogMin1(2*N);
    localparam int unsigned TW       = clogMin1(3*N-2);
    localparam int unsigned DW       = clogMin1(DRAIN+1);
    localparam int unsigned LastBeat = 2*N-1;
    localparam int unsigned LastT    = 3*N-3;
    localparam int unsigned LastD    = DRAIN-1;

    feederState_e   state, stateNext;
    logic [BCW-1:0] beat, beatNext;
    logic [TW-1:0]  tCnt, tNext;
    logic [DW-1:0]  dCnt, dNext;

    logic [BW-1:0] bankA [0:N-1][0:N-1];
    logic [BW-1:0] bankB [0:N-1][0:N-1];
    logic [BW-1:0] aNext [0:N-1][0:N-1];
    logic [BW-1:0] bNext [0:N-1][0:N-1];

    logic [N*BW-1:0] rowVec [0:N-1];
    logic [N*BW-1:0] colVec [0:N-1];
    logic [BW-1:0]   rowSel [0:N-1];
    logic [BW-1:0]   colSel [0:N-1];

    // Next-state, counter and bank-write decode.
    always_comb begin
        stateNext = state;
        beatNext  = beat;
        tNext     = tCnt;
        dNext     = dCnt;
        aNext     = bankA;
        bNext     = bankB;
        case (state)
            StLoad: begin
                if (iValid) begin
                    for (int r = 0; r < int'(N); r++) begin
                        if (beat == BCW'(r)) begin
                            for (int k = 0; k < int'(N); k++) begin
                                aNext[r][k] = iData[k*BW +: BW];
                            end
                        end
                        if (beat == BCW'(int'(N) + r)) begin
                            for (int k = 0; k < int'(N); k++) begin
                                bNext[k][r] = iData[k*BW +: BW];
                            end
                        end
                    end
                    if (beat == BCW'(LastBeat)) begin
                        stateNext = StStream;
                        beatNext  = '0;
                        tNext     = '0;
                    end else begin
                        beatNext = beat + BCW'(1);
                    end
                end
            end
            StStream: begin
                if (tCnt == TW'(LastT)) begin
                    stateNext = StDrain;
                    tNext     = '0;
                    dNext     = '0;
                end else begin
                    tNext = tCnt + TW'(1);
                end
            end
            StDrain: begin
                if (dCnt == DW'(LastD)) begin
                    stateNext = StDone;
                    dNext     = '0;
                end else begin
                    dNext = dCnt + DW'(1);
                end
            end
            StDone: begin
                stateNext = StLoad;
            end
            default: begin
                stateNext = StLoad;
            end
        endcase
    end

    // Flatten the post-write banks into per-lane vectors (rows of A, columns of B).
    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            rowVec[i] = '0;
            colVec[i] = '0;
            for (int k = 0; k < int'(N); k++) begin
                rowVec[i][k*BW +: BW] = aNext[i][k];
                colVec[i][k*BW +: BW] = bNext[k][i];
            end
        end
    end

    // Lane selectors look one cycle ahead so the edge outputs can be registered.
    for (genvar g = 0; g < int'(N); g++) begin : genLane
        systolic_skew_lane #(.BW(BW), .N(N), .LANE(g), .TW(TW)) uRowLane (
            .tIdx   (tNext),
            .vec    (rowVec[g]),
            .elem_c (rowSel[g])
        );
        systolic_skew_lane #(.BW(BW), .N(N), .LANE(g), .TW(TW)) uColLane (
            .tIdx   (tNext),
            .vec    (colVec[g]),
            .elem_c (colSel[g])
        );
    end

    // State, counters, banks and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= StLoad;
            beat   <= '0;
            tCnt   <= '0;
            dCnt   <= '0;
            iReady <= 1'b1;
            oBusy  <= 1'b0;
            oDone  <= 1'b0;
            for (int r = 0; r < int'(N); r++) begin
                oRow[r] <= '0;
                oCol[r] <= '0;
                for (int k = 0; k < int'(N); k++) begin
                    bankA[r][k] <= '0;
                    bankB[r][k] <= '0;
                end
            end
        end else begin
            state  <= stateNext;
            beat   <= beatNext;
            tCnt   <= tNext;
            dCnt   <= dNext;
            bankA  <= aNext;
            bankB  <= bNext;
            iReady <= (stateNext == StLoad);
            oBusy  <= (stateNext == StStream) || (stateNext == StDrain);
            oDone  <= (stateNext == StDone);
            for (int i = 0; i < int'(N); i++) begin
                oRow[i] <= (stateNext == StStream) ? rowSel[i] : '0;
                oCol[i] <= (stateNext == StStream) ? colSel[i] : '0;
            end
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder with N=3, BW=8, DRAIN=3.
module tb_systolic_feeder;

    typedef logic [7:0] mat_t [0:2][0:2];

    logic       clk;
    logic       rst;
    logic       iValid;
    logic       iReady;
    logic [23:0] iData;
    logic [7:0] oRow [0:2];
    logic [7:0] oCol [0:2];
    logic       oBusy;
    logic       oDone;

    systolic_feeder #(.BW(8), .N(3), .DRAIN(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .iValid (iValid),
        .iReady (iReady),
        .iData  (iData),
        .oRow   (oRow),
        .oCol   (oCol),
        .oBusy  (oBusy),
        .oDone  (oDone)
    );

    int passCnt = 0;
    int totalCnt = 0;
    int cyc = 0;
    bit scoreOn = 0;
    int lastDoneCyc = -1;

    logic [47:0] expQ [$];
    int          doneQ [$];
    logic [47:0] hand [0:6];
    logic [47:0] monExp;
    int          monDone;

    logic [23:0] rowPk;
    logic [23:0] colPk;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            rowPk[i*8 +: 8] = oRow[i];
            colPk[i*8 +: 8] = oCol[i];
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic failNote(input string nm);
        totalCnt++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Reference skew: lane i of row edge carries A[i][t-i], lane j of column edge B[t-j][j].
    function automatic logic [47:0] model(input mat_t am, input mat_t bm, input int t);
        logic [47:0] v;
        v = '0;
        for (int i = 0; i < 3; i++) begin
            if (t - i >= 0 && t - i < 3) begin
                v[i*8 +: 8]      = am[i][t-i];
                v[24 + i*8 +: 8] = bm[t-i][i];
            end
        end
        return v;
    endfunction

    // Scoreboard monitor: compares every busy cycle and every done pulse.
    always @(negedge clk) begin
        if (!rst && scoreOn) begin
            if (oBusy) begin
                if (expQ.size() == 0) begin
                    failNote("unexpected_busy");
                end else begin
                    monExp = expQ.pop_front();
                    check("stream_lanes", 64'({colPk, rowPk}), 64'(monExp));
                    check("ready_low_busy", 64'(iReady), 64'(0));
                end
            end else begin
                check("idle_lanes_zero", 64'({colPk, rowPk}), 64'(0));
            end
            if (oDone) begin
                if (doneQ.size() == 0) begin
                    failNote("unexpected_done");
                end else begin
                    monDone = doneQ.pop_front();
                    check("done_cycle", 64'(cyc), 64'(monDone));
                end
                lastDoneCyc = cyc;
            end
        end
    end

    task automatic sendBeat(input logic [23:0] d, output int hs);
        bit acc;
        acc = 0;
        hs = -1;
        iValid = 1'b1;
        iData = d;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk);
            if (iReady) begin
                acc = 1;
                hs = cyc;
            end
            @(posedge clk);
            #1;
        end
        if (!acc) failNote("handshake_timeout");
        iValid = 1'b0;
    endtask

    task automatic runJob(input mat_t am, input mat_t bm, input bit useHand, input bit doPush,
                          input bit gaps, output int firstHs, output int lastHs);
        int hs;
        int n;
        logic [23:0] d;
        hs = -1;
        firstHs = -1;
        for (int bt = 0; bt < 6; bt++) begin
            if (gaps) begin
                n = int'($urandom_range(0, 2));
                iValid = 1'b0;
                iData = 24'($urandom);
                for (int g = 0; g < n; g++) begin
                    @(posedge clk);
                    #1;
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (bt < 3) d[k*8 +: 8] = am[bt][k];
                else        d[k*8 +: 8] = bm[k][bt-3];
            end
            sendBeat(d, hs);
            if (bt == 0) firstHs = hs;
        end
        lastHs = hs;
        if (doPush) begin
            for (int t = 0; t < 10; t++) begin
                if (useHand && t < 7) expQ.push_back(hand[t]);
                else                  expQ.push_back(model(am, bm, t));
            end
            doneQ.push_back(hs + 11);
        end
    endtask

    task automatic waitIdle();
        bit idle;
        idle = 0;
        for (int k = 0; k < 200 && !idle; k++) begin
            @(negedge clk);
            idle = (expQ.size() == 0) && (doneQ.size() == 0) && !oBusy && !oDone;
        end
        if (!idle) failNote("idle_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdleOutputs(input string nm);
        check({nm, "_ready"}, 64'(iReady), 64'(1));
        check({nm, "_busy"},  64'(oBusy),  64'(0));
        check({nm, "_done"},  64'(oDone),  64'(0));
        check({nm, "_lanes"}, 64'({colPk, rowPk}), 64'(0));
    endtask

    mat_t a1, b1, a2, b2, a3, a4, a5, b5, a6, b6;
    int fh, lh, fh5, lh5, fh6, lh6, doneSeen;

    initial begin
        // Hand-derived stream for A=[[1,2,3],[4,5,6],[7,8,9]], B=identity; {col2,col1,col0,row2,row1,row0}.
        hand[0] = {8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1};
        hand[1] = {8'd0, 8'd0, 8'd0, 8'd0, 8'd4, 8'd2};
        hand[2] = {8'd0, 8'd1, 8'd0, 8'd7, 8'd5, 8'd3};
        hand[3] = {8'd0, 8'd0, 8'd0, 8'd8, 8'd6, 8'd0};
        hand[4] = {8'd1, 8'd0, 8'd0, 8'd9, 8'd0, 8'd0};
        hand[5] = 48'd0;
        hand[6] = 48'd0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                a1[r][c] = 8'(3*r + c + 1);
                b1[r][c] = (r == c) ? 8'd1 : 8'd0;
                a2[r][c] = 8'(10 * (3*r + c + 1));
                b2[r][c] = 8'(3*c + r + 1);
                a3[r][c] = 8'h11;
                a4[r][c] = 8'(8'h20 + 3*r + c);
                a5[r][c] = 8'(8'h40 + 3*r + c);
                b5[r][c] = 8'(8'h50 + 3*r + c);
                a6[r][c] = 8'(8'hA0 + 3*r + c);
                b6[r][c] = 8'(8'hC0 + 3*r + c);
            end
        end

        rst = 1'b1;
        iValid = 1'b1;
        iData = 24'h030201;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkIdleOutputs("in_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        iValid = 1'b0;
        @(negedge clk);
        checkIdleOutputs("after_reset");
        @(posedge clk);
        #1;
        scoreOn = 1;

        // Job 1: hand-checked stream and done latency.
        runJob(a1, b1, 1'b1, 1'b1, 1'b0, fh, lh);
        waitIdle();

        // Job 2: random gaps during load, iValid held high with junk through stream/drain.
        runJob(a2, b2, 1'b0, 1'b1, 1'b1, fh, lh);
        iValid = 1'b1;
        iData = 24'hEEEEEE;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        iValid = 1'b0;
        waitIdle();

        // Job 3: abort with reset at stream t=3.
        scoreOn = 0;
        runJob(a3, b1, 1'b0, 1'b0, 1'b0, fh, lh);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("abort_t3_busy", 64'(oBusy), 64'(1));
        check("abort_t3_lanes", 64'({colPk, rowPk}), 64'(model(a3, b1, 3)));
        rst = 1'b1;
        @(negedge clk);
        checkIdleOutputs("abort_load");
        rst = 1'b0;
        doneSeen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (oDone) doneSeen++;
        end
        check("abort_no_done", 64'(doneSeen), 64'(0));
        @(posedge clk);
        #1;
        scoreOn = 1;

        // Job 4: normal job after an abort.
        runJob(a4, b1, 1'b0, 1'b1, 1'b0, fh, lh);
        waitIdle();

        // Jobs 5 and 6 back to back; job 6's first beat waits out job 5's stream.
        runJob(a5, b5, 1'b0, 1'b1, 1'b0, fh5, lh5);
        runJob(a6, b6, 1'b0, 1'b1, 1'b0, fh6, lh6);
        check("b2b_first_beat", 64'(fh6), 64'(lh5 + 12));
        check("b2b_after_done", 64'(fh6), 64'(lastDoneCyc + 1));
        waitIdle();

        check("expq_empty", 64'(expQ.size()), 64'(0));
        check("doneq_empty", 64'(doneQ.size()), 64'(0));
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
